// File: rtl/up_down_count_checker.sv
// Scoreboard for an external up/down counter: predicts q each cycle, flags and counts mismatches.
// Optional: define UP_DOWN_COUNT_CHECKER_RESYNC_EN to re-base the prediction on q after a mismatch.
module up_down_count_checker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 check_en,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     in,
  input  logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     exp_q,
  output logic                 mismatch,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

`ifdef UP_DOWN_COUNT_CHECKER_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       pred_q, pred_d;
  logic                   mismatch_q, mismatch_d;
  logic                   err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic                   halted_q, halted_d;

  logic                   miss;
  logic [WIDTH-1:0]       base;

  always_comb begin
    state_d     = state_q;
    mismatch_d  = 1'b0;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;

    miss = (state_q == TRACK) && (q != pred_q);
    // On a mismatch with resync enabled, follow the observed counter so one fault counts once
    base = (RESYNC && miss) ? q : pred_q;
    if (load)      pred_d = in;
    else if (mode) pred_d = base + 1'b1;
    else           pred_d = base - 1'b1;

    case (state_q)
      IDLE: begin
        if (check_en) state_d = TRACK;
      end
      TRACK: begin
        if (miss) begin
          mismatch_d = 1'b1;
          err_flag_d = 1'b1;
          if (err_count_q != ERR_MAX) err_count_d = err_count_q + 1'b1;
        end
        if (miss && (err_count_d == ERR_MAX)) state_d = HALT;
        else if (!check_en)                   state_d = IDLE;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over anything detected on the same edge
    if (clear) begin
      state_d     = IDLE;
      mismatch_d  = 1'b0;
      err_flag_d  = 1'b0;
      err_count_d = '0;
    end

    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pred_q      <= '0;
      mismatch_q  <= 1'b0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      mismatch_q  <= mismatch_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
      halted_q    <= halted_d;
    end
  end

  assign exp_q     = pred_q;
  assign mismatch  = mismatch_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_up_down_count_checker.sv
// Directed bench for up_down_count_checker; a second instance with ERR_CNT_W=2 covers saturation/HALT.
module tb_up_down_count_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       check_en, clear, load, mode;
  logic [3:0] in, q;

  logic [3:0] exp_q,  exp_q2;
  logic       mismatch, err_flag, halted;
  logic       mismatch2, err_flag2, halted2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  up_down_count_checker #(.WIDTH(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .check_en(check_en), .clear(clear), .load(load),
    .mode(mode), .in(in), .q(q), .exp_q(exp_q), .mismatch(mismatch),
    .err_flag(err_flag), .err_count(err_count), .halted(halted)
  );

  up_down_count_checker #(.WIDTH(4), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .check_en(check_en), .clear(clear), .load(load),
    .mode(mode), .in(in), .q(q), .exp_q(exp_q2), .mismatch(mismatch2),
    .err_flag(err_flag2), .err_count(err_count2), .halted(halted2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vecs++;
    assert (got === expv) else begin
      errs++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

`ifdef UP_DOWN_COUNT_CHECKER_RESYNC_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  initial begin
    rst = 1'b0; check_en = 1'b0; clear = 1'b0; load = 1'b0; mode = 1'b0;
    in = 4'd0; q = 4'd0;
    #2;
    chk("rst_exp_q", exp_q, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_halted", halted, 0);

    // Load 3 counting up, correct q
    rst = 1'b1; check_en = 1'b1; load = 1'b1; in = 4'd3; mode = 1'b1;
    tick(); chk("ld3_exp", exp_q, 3);  q = 4'd3; load = 1'b0;
    tick(); chk("up_exp4", exp_q, 4);  q = 4'd4;
    tick(); chk("up_exp5", exp_q, 5);  q = 4'd5;
    tick(); chk("up_exp6", exp_q, 6);  q = 4'd6;
    tick(); chk("up_exp7", exp_q, 7);
    chk("good_mismatch", mismatch, 0);
    chk("good_err_count", err_count, 0);
    q = 4'd7; load = 1'b1; in = 4'd14;

    // Wrap 14,15,0,1 up then 0,15 down
    tick(); chk("wr_exp14", exp_q, 14); q = 4'd14; load = 1'b0;
    tick(); chk("wr_exp15", exp_q, 15); q = 4'd15;
    tick(); chk("wr_exp0",  exp_q, 0);  q = 4'd0;
    tick(); chk("wr_exp1",  exp_q, 1);  q = 4'd1; mode = 1'b0;
    tick(); chk("dn_exp0",  exp_q, 0);  q = 4'd0;
    tick(); chk("dn_exp15", exp_q, 15); q = 4'd15;
    chk("wrap_mismatch", mismatch, 0);
    chk("wrap_err_count", err_count, 0);
    load = 1'b1; in = 4'd3; mode = 1'b1;

    // Fault: q=7 while exp_q=5
    tick(); chk("f_exp3", exp_q, 3); q = 4'd3; load = 1'b0;
    tick(); chk("f_exp4", exp_q, 4); q = 4'd4;
    tick(); chk("f_exp5", exp_q, 5); q = 4'd7;
    tick();
    chk("f_mismatch", mismatch, 1);
    chk("f_err_flag", err_flag, 1);
    chk("f_err_count", err_count, 1);
    chk("f_exp_a", exp_q, RS ? 8 : 6);
    q = 4'd8;
    tick();
    chk("f_mismatch_b", mismatch, RS ? 0 : 1);
    chk("f_exp_b", exp_q, RS ? 9 : 7);
    q = 4'd9;
    tick();
    chk("f_err_count_c", err_count, RS ? 1 : 3);
    chk("f_exp_c", exp_q, RS ? 10 : 8);
    chk("f_err_flag_c", err_flag, 1);
    q = 4'd10; clear = 1'b1; check_en = 1'b0;

    // Clear (beats the simultaneous mismatch when resync is off)
    tick();
    chk("clr_mismatch", mismatch, 0);
    chk("clr_err_flag", err_flag, 0);
    chk("clr_err_count", err_count, 0);
    chk("clr_halted", halted, 0);
    clear = 1'b0; check_en = 1'b1; load = 1'b1; in = 4'd0; q = 4'd0;

    // Mid-cycle async reset with err_flag set
    tick(); chk("r_exp0", exp_q, 0); q = 4'd2; load = 1'b0;
    tick(); chk("r_err_flag", err_flag, 1); chk("r_mismatch", mismatch, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_exp_q", exp_q, 0);
    chk("ar_mismatch", mismatch, 0);
    chk("ar_err_flag", err_flag, 0);
    chk("ar_err_count", err_count, 0);
    chk("ar_halted", halted, 0);
    check_en = 1'b0; q = 4'd9;
    #1 rst = 1'b1;
    tick();
    chk("idle_no_cmp", mismatch, 0);
    chk("idle_exp1", exp_q, 1);
    check_en = 1'b1; load = 1'b1; in = 4'd0;

    // Saturation with ERR_CNT_W=2: persistent q=9
    tick(); chk("s_exp0", exp_q2, 0); load = 1'b0;
    tick(); chk("s_cnt1", err_count2, 1); chk("s_halt1", halted2, 0);
    tick(); chk("s_cnt2", err_count2, 2); chk("s_halt2", halted2, 0);
    tick(); chk("s_cnt3", err_count2, 3); chk("s_halt3", halted2, 1); chk("s_mis3", mismatch2, 1);
    tick();
    chk("h_mis", mismatch2, 0);
    chk("h_cnt", err_count2, 3);
    chk("h_halt", halted2, 1);
    chk("h_flag", err_flag2, 1);
    clear = 1'b1;
    tick();
    chk("hc_cnt", err_count2, 0);
    chk("hc_flag", err_flag2, 0);
    chk("hc_halt", halted2, 0);
    chk("hc_mis", mismatch2, 0);
    clear = 1'b0; check_en = 1'b0;
    tick();
    chk("hc_idle_mis", mismatch2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/up_down_count_checker.md
UP_DOWN_COUNT_CHECKER -- requirements
Module: up_down_count_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the observed counter value.
REQ-002 SHALL have parameter ERR_CNT_W, default 8: width of the mismatch counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port check_en, input, 1 bit: 1 enables checking.
REQ-006 SHALL have port clear, input, 1 bit: synchronous clear of error state.
REQ-007 SHALL have port load, input, 1 bit: observed counter load strobe.
REQ-008 SHALL have port mode, input, 1 bit: observed direction; 1 = up, 0 = down.
REQ-009 SHALL have port in, input, WIDTH bits: observed counter load data.
REQ-010 SHALL have port q, input, WIDTH bits: observed counter output.
REQ-011 SHALL have port exp_q, output, WIDTH bits: predicted value of q for the current cycle.
REQ-012 SHALL have port mismatch, output, 1 bit: one-cycle pulse per detected mismatch.
REQ-013 SHALL have port err_flag, output, 1 bit: sticky error indicator.
REQ-014 SHALL have port err_count, output, ERR_CNT_W bits: saturating mismatch count.
REQ-015 SHALL have port halted, output, 1 bit: high while the FSM is in HALT.

Function
REQ-016 SHALL model the observed counter as: load=1 -> next = in; else mode=1 -> next = q+1; else next = q-1; arithmetic is modulo 2^WIDTH (15+1 = 0, 0-1 = 15).
REQ-017 SHALL implement FSM states IDLE, TRACK and HALT.
REQ-018 SHALL, in IDLE, update exp_q per REQ-016 from exp_q without comparing, and move to TRACK on the edge where check_en=1.
REQ-019 SHALL, in TRACK, compare q with exp_q on every edge; on inequality, register mismatch=1 for exactly the following cycle.
REQ-020 SHALL update exp_q every edge in TRACK: next = in if load=1, else exp_q±1 per mode (see REQ-031 for resync).
REQ-021 SHALL set err_flag on the edge that registers a mismatch and hold it until clear or reset.
REQ-022 SHALL increment err_count by 1 per mismatch, saturating at 2^ERR_CNT_W-1.
REQ-023 SHALL move TRACK -> HALT on the edge where err_count reaches saturation; in HALT, comparisons stop, mismatch=0 and err_count is frozen.
REQ-024 SHALL move TRACK -> IDLE when check_en=0; err_flag and err_count are retained.
REQ-025 SHALL, on clear=1, zero err_flag, err_count and mismatch and move to IDLE from any state; clear has priority over a simultaneous mismatch.
REQ-026 SHALL treat load=1 together with a mismatch as follows: the mismatch is counted and exp_q takes in.

Reset
REQ-027 SHALL, while rst=0, immediately force state=IDLE, exp_q=0, mismatch=0, err_flag=0, err_count=0 and halted=0.
REQ-028 SHALL drop any in-flight mismatch pulse if reset is asserted mid-operation.
REQ-029 SHALL resume operation on the first rising edge after rst returns to 1.

Configuration
REQ-030 SHALL use the macro UP_DOWN_COUNT_CHECKER_RESYNC_EN.
REQ-031 SHALL, with the macro defined, base the next exp_q on the observed q (q±1, or in if load=1) on a mismatch edge, so one fault yields one mismatch.
REQ-032 SHALL, without the macro, always base the next exp_q on exp_q, so a persistent offset yields a mismatch on every TRACK cycle.

Verification
REQ-033 SHALL cover: reset, check_en=1, one-cycle load with in=3 and mode=1, correct DUT q=3,4,5,6 -> mismatch never asserted, err_count=0.
REQ-034 SHALL cover: load 14 with mode=1, then mode=0 after reaching 1 -> exp_q=14,15,0,1,0,15 with no mismatch.
REQ-035 SHALL cover: q forced to 7 while exp_q=5 -> mismatch=1 for exactly one cycle, err_flag=1, err_count=1.
REQ-036 SHALL cover, with q continuing 8,9: macro defined -> exp_q=8,9 and err_count stays 1; macro undefined -> exp_q=6,7 and err_count=3.
REQ-037 SHALL cover: ERR_CNT_W=2 with 4 mismatches -> halted=1 after the third, err_count=3 frozen; then clear=1 -> IDLE, err_count=0, err_flag=0.
REQ-038 SHALL cover: rst=0 asserted between clock edges in TRACK with err_flag=1 -> all outputs 0 and state IDLE before the next edge.
